// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB3-Lite encodings plus the memory-loader state type
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_BYTE   = 3'b000;
  localparam logic [2:0] HSIZE_HWORD  = 3'b001;
  localparam logic [2:0] HSIZE_WORD   = 3'b010;
  localparam logic [2:0] HSIZE_DWORD  = 3'b011;
  localparam logic [2:0] HSIZE_4WLINE = 3'b100;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
  localparam int AHB_1K_BOUNDARY_BITS = 10;
  typedef enum logic [1:0] {IDLE, XFER, LAST, FIN} loader_state_t;
  function automatic logic [2:0] hsize_of(input int data_bits);
    return 3'($clog2(data_bits / 8));
  endfunction
endpackage

// File: rtl/ahb3lite_mem_loader.sv
// ahb3lite_mem_loader: writes a valid/ready stream to consecutive words as one AHB3-Lite INCR burst; AHB3LITE_LOADER_CHECKSUM_EN adds csum_o
module ahb3lite_mem_loader
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int LEN_SIZE   = 16
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  input  logic                  start_i,
  input  logic [HADDR_SIZE-1:0] base_i,
  input  logic [LEN_SIZE-1:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  s_valid_i,
  input  logic [HDATA_SIZE-1:0] s_data_i,
  output logic                  s_ready_o,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic                  HRESP
`ifdef AHB3LITE_LOADER_CHECKSUM_EN
  ,
  output logic [HDATA_SIZE-1:0] csum_o
`endif
);
  localparam int BE_SIZE = HDATA_SIZE / 8;
  localparam logic [HADDR_SIZE-1:0] ADDR_INC   = HADDR_SIZE'(BE_SIZE);
  localparam logic [HADDR_SIZE-1:0] ALIGN_MASK = ~(HADDR_SIZE'(BE_SIZE - 1));
  loader_state_t         state;
  logic [HADDR_SIZE-1:0] addr_q;
  logic [LEN_SIZE-1:0]   rem_q;
  logic [HDATA_SIZE-1:0] wdata_q;
  logic                  beat_q;
  logic                  pop;
  logic                  err_hit;
  logic                  restart;
  assign s_ready_o = (state == XFER) & HREADY & (rem_q != '0);
  assign pop       = s_valid_i & s_ready_o;
  assign err_hit   = ((state == XFER) | (state == LAST)) & (HRESP == HRESP_ERROR) & ~HREADY;
  assign restart   = ~beat_q | (addr_q[AHB_1K_BOUNDARY_BITS-1:0] == '0);
  assign HWRITE    = 1'b1;
  assign HSIZE     = hsize_of(HDATA_SIZE);
  assign HBURST    = HBURST_INCR;
  assign HPROT     = HPROT_DATA_PRIV;
  assign HMASTLOCK = 1'b0;
  // burst FSM: address phase generation, data phase register and completion pulses
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wdata_q <= '0;
      beat_q  <= 1'b0;
      HADDR   <= '0;
      HWDATA  <= '0;
      HTRANS  <= HTRANS_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      if (HREADY && HTRANS[1]) HWDATA <= wdata_q;
      if (state == IDLE) begin
        if (start_i) begin
          addr_q <= base_i & ALIGN_MASK;
          rem_q  <= len_i;
          beat_q <= 1'b0;
          busy_o <= 1'b1;
          done_o <= (len_i == '0);
          state  <= (len_i == '0) ? FIN : XFER;
        end
      end else if (err_hit) begin
        HTRANS <= HTRANS_IDLE;
        done_o <= 1'b1;
        err_o  <= 1'b1;
        state  <= FIN;
      end else if (state == XFER && HREADY) begin
        if (pop) begin
          HADDR   <= addr_q;
          HTRANS  <= restart ? HTRANS_NONSEQ : HTRANS_SEQ;
          wdata_q <= s_data_i;
          addr_q  <= addr_q + ADDR_INC;
          rem_q   <= rem_q - 1'b1;
          beat_q  <= 1'b1;
          if (rem_q == LEN_SIZE'(1)) state <= LAST;
        end else if (beat_q) begin
          HTRANS <= HTRANS_BUSY;
          HADDR  <= addr_q;
        end else begin
          HTRANS <= HTRANS_IDLE;
        end
      end else if (state == LAST && HREADY) begin
        HTRANS <= HTRANS_IDLE;
        if (HTRANS == HTRANS_IDLE) begin
          done_o <= 1'b1;
          state  <= FIN;
        end
      end else if (state == FIN) begin
        busy_o <= 1'b0;
        state  <= IDLE;
      end
    end
  end
`ifdef AHB3LITE_LOADER_CHECKSUM_EN
  // running sum of every popped word, restarted by each accepted transfer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) csum_o <= '0;
    else if (state == IDLE && start_i) csum_o <= '0;
    else if (pop) csum_o <= csum_o + s_data_i;
  end
`endif
endmodule

// File: tb/tb_ahb3lite_mem_loader.sv
// tb_ahb3lite_mem_loader: directed scenarios for the AHB3-Lite stream-to-memory loader
module tb_ahb3lite_mem_loader;
  logic        HRESETn, HCLK;
  logic        start_i;
  logic [31:0] base_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o;
  logic        s_valid_i, s_ready_o;
  logic [31:0] s_data_i;
  logic [31:0] HADDR, HWDATA;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
`ifdef AHB3LITE_LOADER_CHECKSUM_EN
  logic [31:0] csum_o;
`endif

  ahb3lite_mem_loader dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
`ifdef AHB3LITE_LOADER_CHECKSUM_EN
    , .csum_o(csum_o)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {logic [31:0] a; logic [1:0] t; logic [31:0] d; logic r;} wrec_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int s0 = 0;
  logic [31:0] src[$];
  int src_i = 0;
  int gap_after = -1;
  int gap_cnt = 0;
  logic [1:0] rsp_q[$];
  logic [33:0] aq[$];
  logic [31:0] wq[$];
  logic [31:0] bq[$];
  wrec_t wr[$];
  int done_n, err_n, errd_n, done_cyc;
  logic [1:0] done_tr;
  logic done_busy;
  logic dp = 1'b0;

  // bus observer: records completed address phases, data phases, BUSY and wait cycles, completion pulses
  always @(negedge HCLK) begin
    if (!HRESETn) dp = 1'b0;
    else begin
      if (HREADY) begin
        if (dp) wq.push_back(HWDATA);
        if (HTRANS[1]) aq.push_back({HTRANS, HADDR});
        dp = HTRANS[1];
      end else begin
        wr.push_back('{a: HADDR, t: HTRANS, d: HWDATA, r: s_ready_o});
      end
      if (HTRANS == 2'b01) bq.push_back(HADDR);
      if (done_o) begin
        done_n++;
        done_cyc = cyc;
        done_tr = HTRANS;
        done_busy = busy_o;
        if (err_o) errd_n++;
      end
      if (err_o) err_n++;
    end
  end

  task automatic tick();
    logic acc, gap;
    if (rsp_q.size() > 0) {HREADY, HRESP} = rsp_q.pop_front();
    else {HREADY, HRESP} = 2'b10;
    gap = (src_i == gap_after) && (gap_cnt > 0);
    s_valid_i = !gap && (src_i < src.size());
    s_data_i = s_valid_i ? src[src_i] : 32'h0;
    @(negedge HCLK);
    acc = s_valid_i && s_ready_o;
    @(posedge HCLK);
    #1;
    if (acc) src_i++;
    if (gap) gap_cnt--;
    cyc++;
  endtask

  task automatic launch(input logic [31:0] b, input logic [15:0] l);
    aq.delete(); wq.delete(); bq.delete(); wr.delete();
    done_n = 0; err_n = 0; errd_n = 0; done_cyc = -1;
    start_i = 1'b1; base_i = b; len_i = l;
    s0 = cyc;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input string name);
    int n = 0;
    while (done_n == 0 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (done_n == 0) begin
      miscompares++;
      $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, n);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; start_i = 0; base_i = 0; len_i = 0; s_valid_i = 0; s_data_i = 0;
    HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    vectors++;
    if ({HTRANS, HADDR, HWDATA, busy_o, done_o, err_o, s_ready_o} !== 70'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got trans=%h addr=%h wdata=%h busy=%b done=%b err=%b ready=%b want all zero",
               HTRANS, HADDR, HWDATA, busy_o, done_o, err_o, s_ready_o);
    end
    vectors++;
    if ({HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK} !== {1'b1, 3'b010, 3'b001, 4'b0011, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got write=%b size=%h burst=%h prot=%h lock=%b want 1/2/1/3/0",
               HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK);
    end
    HRESETn = 1'b1;
    tick();
    vectors++;
    if (HTRANS !== 2'b00 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got trans=%h busy=%b want 0/0", HTRANS, busy_o);
    end
  endtask

  task automatic test_single_burst();
    logic [33:0] ea[4] = '{{2'b10, 32'h100}, {2'b11, 32'h104}, {2'b11, 32'h108}, {2'b11, 32'h10C}};
    logic [31:0] ew[4] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    src = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004}; src_i = 0; gap_cnt = 0;
    launch(32'h100, 16'd4);
    run_until_done("single");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (aq.size() <= i || aq[i] !== ea[i]) begin
        miscompares++;
        $display("FAIL single_addr%0d: got %h want %h", i, (aq.size() > i) ? aq[i] : 34'h0, ea[i]);
      end
      vectors++;
      if (wq.size() <= i || wq[i] !== ew[i]) begin
        miscompares++;
        $display("FAIL single_data%0d: got %h want %h", i, (wq.size() > i) ? wq[i] : 32'h0, ew[i]);
      end
    end
    vectors++;
    if (done_cyc - s0 != 7 || done_n != 1 || err_n != 0) begin
      miscompares++;
      $display("FAIL single_done: got latency=%0d pulses=%0d errs=%0d want 7/1/0", done_cyc - s0, done_n, err_n);
    end
    vectors++;
    if (busy_o !== 1'b0 || aq.size() != 4) begin
      miscompares++;
      $display("FAIL single_end: got busy=%b beats=%0d want 0/4", busy_o, aq.size());
    end
  endtask

  task automatic test_stream_gap();
    logic [33:0] ea[4] = '{{2'b10, 32'h100}, {2'b11, 32'h104}, {2'b11, 32'h108}, {2'b11, 32'h10C}};
    logic [31:0] ew[4] = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444};
    src = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444}; src_i = 0;
    gap_after = 2; gap_cnt = 2;
    launch(32'h100, 16'd4);
    run_until_done("gap");
    gap_after = -1;
    vectors++;
    if (bq.size() != 2 || bq[0] !== 32'h108 || bq[1] !== 32'h108) begin
      miscompares++;
      $display("FAIL gap_busy: got %0d BUSY cycles first addr %h want 2 at 00000108",
               bq.size(), (bq.size() > 0) ? bq[0] : 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (aq.size() <= i || aq[i] !== ea[i] || wq.size() <= i || wq[i] !== ew[i]) begin
        miscompares++;
        $display("FAIL gap_beat%0d: got addr %h data %h want %h %h", i,
                 (aq.size() > i) ? aq[i] : 34'h0, (wq.size() > i) ? wq[i] : 32'h0, ea[i], ew[i]);
      end
    end
    vectors++;
    if (done_cyc - s0 != 9) begin
      miscompares++;
      $display("FAIL gap_done: got latency %0d want 9", done_cyc - s0);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] ew[4] = '{32'h5555_0000, 32'h6666_0001, 32'h7777_0002, 32'h8888_0003};
    src = '{32'h5555_0000, 32'h6666_0001, 32'h7777_0002, 32'h8888_0003}; src_i = 0;
    rsp_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    launch(32'h100, 16'd4);
    run_until_done("wait");
    vectors++;
    if (wr.size() != 3) begin
      miscompares++;
      $display("FAIL wait_count: got %0d wait cycles want 3", wr.size());
    end
    foreach (wr[i]) begin
      vectors++;
      if (wr[i].a !== 32'h108 || wr[i].t !== 2'b11 || wr[i].d !== 32'h6666_0001 || wr[i].r !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_hold%0d: got addr=%h trans=%h wdata=%h ready=%b want 00000108/3/66660001/0",
                 i, wr[i].a, wr[i].t, wr[i].d, wr[i].r);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wq.size() <= i || wq[i] !== ew[i]) begin
        miscompares++;
        $display("FAIL wait_data%0d: got %h want %h", i, (wq.size() > i) ? wq[i] : 32'h0, ew[i]);
      end
    end
    vectors++;
    if (done_cyc - s0 != 10) begin
      miscompares++;
      $display("FAIL wait_done: got latency %0d want 10", done_cyc - s0);
    end
  endtask

  task automatic test_1k_boundary();
    logic [33:0] ea[4] = '{{2'b10, 32'h3F8}, {2'b11, 32'h3FC}, {2'b10, 32'h400}, {2'b11, 32'h404}};
    src = '{32'h1, 32'h2, 32'h3, 32'h4}; src_i = 0;
    launch(32'h3FB, 16'd4);
    run_until_done("k1");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (aq.size() <= i || aq[i] !== ea[i]) begin
        miscompares++;
        $display("FAIL k1_addr%0d: got %h want %h", i, (aq.size() > i) ? aq[i] : 34'h0, ea[i]);
      end
    end
  endtask

  task automatic test_error();
    logic [33:0] ea[3] = '{{2'b10, 32'h100}, {2'b11, 32'h104}, {2'b11, 32'h108}};
    src = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17}; src_i = 0;
    rsp_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    launch(32'h100, 16'd8);
    run_until_done("err");
    vectors++;
    if (aq.size() != 3) begin
      miscompares++;
      $display("FAIL err_beats: got %0d beats want 3", aq.size());
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (aq.size() <= i || aq[i] !== ea[i]) begin
        miscompares++;
        $display("FAIL err_addr%0d: got %h want %h", i, (aq.size() > i) ? aq[i] : 34'h0, ea[i]);
      end
    end
    vectors++;
    if (done_n != 1 || err_n != 1 || errd_n != 1 || done_cyc - s0 != 6 || done_tr !== 2'b00) begin
      miscompares++;
      $display("FAIL err_pulse: got done=%0d err=%0d together=%0d latency=%0d trans=%h want 1/1/1/6/0",
               done_n, err_n, errd_n, done_cyc - s0, done_tr);
    end
    vectors++;
    if (src_i != 4) begin
      miscompares++;
      $display("FAIL err_popped: got %0d words taken want 4", src_i);
    end
  endtask

  task automatic test_len_zero();
    src = '{32'hDEAD_BEEF}; src_i = 0;
    launch(32'h200, 16'd0);
    run_until_done("len0");
    vectors++;
    if (done_cyc - s0 != 1 || done_busy !== 1'b1 || aq.size() != 0 || bq.size() != 0 || src_i != 0) begin
      miscompares++;
      $display("FAIL len0: got latency=%0d busy=%b beats=%0d busy_beats=%0d popped=%0d want 1/1/0/0/0",
               done_cyc - s0, done_busy, aq.size(), bq.size(), src_i);
    end
  endtask

  task automatic test_ignore_start();
    src = '{32'hAA, 32'hBB, 32'hCC, 32'hDD, 32'hEE}; src_i = 0;
    launch(32'h200, 16'd2);
    start_i = 1'b1; base_i = 32'h800; len_i = 16'd5;
    repeat (3) tick();
    start_i = 1'b0;
    run_until_done("busy_start");
    vectors++;
    if (aq.size() != 2 || aq[0] !== {2'b10, 32'h200} || aq[1] !== {2'b11, 32'h204} || done_n != 1 || done_cyc - s0 != 5) begin
      miscompares++;
      $display("FAIL busy_start: got beats=%0d first=%h done=%0d latency=%0d want 2/200000200/1/5",
               aq.size(), (aq.size() > 0) ? aq[0] : 34'h0, done_n, done_cyc - s0);
    end
  endtask

`ifdef AHB3LITE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    src = '{32'h1, 32'h2, 32'h3, 32'hFFFF_FFFF}; src_i = 0;
    launch(32'h0, 16'd4);
    run_until_done("csum");
    vectors++;
    if (csum_o !== 32'h0000_0005) begin
      miscompares++;
      $display("FAIL csum: got %h want 00000005", csum_o);
    end
  endtask
`endif

  task automatic test_reset_mid();
    src = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8}; src_i = 0;
    launch(32'h500, 16'd8);
    repeat (4) tick();
    HRESETn = 1'b0;
    #1;
    vectors++;
    if ({HTRANS, HADDR, HWDATA, busy_o, done_o, err_o, s_ready_o} !== 70'h0) begin
      miscompares++;
      $display("FAIL rst_mid: got trans=%h addr=%h wdata=%h busy=%b done=%b err=%b ready=%b want all zero",
               HTRANS, HADDR, HWDATA, busy_o, done_o, err_o, s_ready_o);
    end
    repeat (2) tick();
    HRESETn = 1'b1;
    repeat (5) tick();
    vectors++;
    if (done_n != 0 || busy_o !== 1'b0 || HTRANS !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_after: got done=%0d busy=%b trans=%h want 0/0/0", done_n, busy_o, HTRANS);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_stream_gap();
    test_wait_states();
    test_1k_boundary();
    test_error();
    test_len_zero();
    test_ignore_start();
`ifdef AHB3LITE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
